// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: guard/active dwell per digit, frame-aligned display
// word update, leading-zero blanking. Optional blink feature enabled by defining SEG_BLINK_EN.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD_CYC   = 16,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_valid,
  input  logic [4*NUM_DIGITS-1:0] wr_data,
  output logic                    wr_ready,
  input  logic                    lzb,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
`ifdef SEG_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
  output logic [3:0]              dec_in,
  output logic                    dec_en,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    dp,
  output logic                    frame_start
);

  localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int MAX_DWELL = (REFRESH_DIV > GUARD_CYC) ? REFRESH_DIV : GUARD_CYC;
  localparam int CNT_W     = $clog2(MAX_DWELL + 1);

  typedef enum logic {ST_GUARD, ST_ACTIVE} state_t;

  state_t                  r_state, w_state_nxt;
  logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]        r_idx, w_idx_nxt;
  logic [4*NUM_DIGITS-1:0] r_shadow, w_shadow_nxt, r_pend_data, w_hi;
  logic                    r_pending, w_accept, w_boundary, w_blink, w_blank, w_dp;
  logic [NUM_DIGITS-1:0]   w_onehot, w_an;
  logic [3:0]              w_nib;
  logic [3:0]              r_dec_in;
  logic                    r_dec_en, r_dp, r_frame_start;
  logic [NUM_DIGITS-1:0]   r_an;

  assign w_accept = wr_valid & ~r_pending;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_idx_nxt   = r_idx;
    w_boundary  = 1'b0;
    case (r_state)
      ST_GUARD: if (r_cnt == CNT_W'(GUARD_CYC - 1)) begin
        w_state_nxt = ST_ACTIVE;
        w_cnt_nxt   = '0;
        w_boundary  = (r_idx == '0);
      end
      ST_ACTIVE: if (r_cnt == CNT_W'(REFRESH_DIV - 1)) begin
        w_state_nxt = ST_GUARD;
        w_cnt_nxt   = '0;
        w_idx_nxt   = (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
      end
      default: w_state_nxt = ST_GUARD;
    endcase
    w_shadow_nxt = (w_boundary && r_pending) ? r_pend_data : r_shadow;
  end

`ifdef SEG_BLINK_EN
  localparam int BLINK_W = $clog2(BLINK_DIV + 1);
  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_blink_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (r_blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_blink_cnt   <= r_blink_cnt + 1'b1;
    end
  end

  assign w_blink = r_blink_phase & blink_mask[w_idx_nxt];
`else
  assign w_blink = 1'b0;
`endif

  // Display values for the digit that will be active after this edge, using the post-update shadow.
  always_comb begin
    w_onehot = NUM_DIGITS'(1) << w_idx_nxt;
    w_hi     = w_shadow_nxt >> (4 * w_idx_nxt);
    w_nib    = w_hi[3:0];
    w_blank  = w_blink | (lzb && (w_idx_nxt != '0) && (w_hi == '0));
    w_an     = w_blank ? '1 : ~w_onehot;
    w_dp     = w_blink | ~dp_mask[w_idx_nxt];
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_GUARD;
      r_cnt         <= '0;
      r_idx         <= '0;
      r_shadow      <= '0;
      r_pending     <= 1'b0;
      r_dec_in      <= '0;
      r_dec_en      <= 1'b0;
      r_an          <= '1;
      r_dp          <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_idx         <= w_idx_nxt;
      r_shadow      <= w_shadow_nxt;
      r_frame_start <= w_boundary;
      if (w_accept)        r_pending <= 1'b1;
      else if (w_boundary) r_pending <= 1'b0;
      if (w_state_nxt == ST_ACTIVE) begin
        r_dec_in <= w_nib;
        r_an     <= w_an;
        r_dec_en <= ~w_blank;
        r_dp     <= w_dp;
      end else begin
        r_an     <= '1;
        r_dec_en <= 1'b0;
        r_dp     <= 1'b1;
      end
    end
  end

  // NOTE: the pending word is only read while r_pending is set, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_accept) r_pend_data <= wr_data;
  end

  assign wr_ready    = ~r_pending;
  assign dec_in      = r_dec_in;
  assign dec_en      = r_dec_en;
  assign an          = r_an;
  assign dp          = r_dp;
  assign frame_start = r_frame_start;

endmodule
